// File: rtl/arith_pkg.sv
// Shared types for the sequential arithmetic unit: operation codes, FSM states
// and a counter-width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC1 = 3'd1,
        MULT  = 3'd2,
        DIVD  = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Bits needed for an iteration counter that must reach the value w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/arith_div_core.sv
// W-iteration restoring divider: start latches the operands, busy stays high for
// W cycles, then q/r hold quotient and remainder. Divisor must be non-zero.
module arith_div_core
    import arith_pkg::*;
#(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic [W-1:0] q,
    output logic [W-1:0] r
);

    localparam int CW = cnt_width(W);

    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [W:0]    trial_s;
    logic [W:0]    diff_s;

    // One restoring step per cycle: shift the next dividend bit into the partial remainder.
    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        trial_s = {rem_q, quo_q[W-1]};
        diff_s  = trial_s - {1'b0, dvs_q};
        if (start) begin
            quo_d  = dividend;
            rem_d  = {W{1'b0}};
            dvs_d  = divisor;
            cnt_d  = {CW{1'b0}};
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (trial_s >= {1'b0, dvs_q}) begin
                rem_d = diff_s[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = trial_s[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d  = cnt_q + CW'(1);
            busy_d = (cnt_q != CW'(W - 1));
        end else begin
            busy_d = 1'b0;
        end
    end

    // Divider state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo_q  <= {W{1'b0}};
            rem_q  <= {W{1'b0}};
            dvs_q  <= {W{1'b0}};
            cnt_q  <= {CW{1'b0}};
            busy_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign q    = quo_q;
    assign r    = rem_q;

endmodule

// File: rtl/seq_arith_unit.sv
// Multi-cycle ADD/SUB/MUL/DIV unit with start/ready/done handshake and held results.
// Macro ARITH_DIV_EN enables the restoring divider; otherwise DIV reports err.
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int W = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  op_t            op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           ready,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic [W-1:0]   rem,
    output logic           neg,
    output logic           err
);

    localparam int CW = cnt_width(W);

    state_t         state_q, state_d;
    op_t            op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] result_q, result_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           neg_q, neg_d;
    logic           err_q, err_d;
    logic           ready_q, ready_d;
    logic           done_q, done_d;
    logic           accept_s;
    logic [W:0]     sum_s;
    logic [W-1:0]   diff_s;

`ifdef ARITH_DIV_EN
    logic           div_start_s;
    logic           div_busy_s;
    logic [W-1:0]   div_q_s;
    logic [W-1:0]   div_r_s;

    arith_div_core #(.W(W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start_s),
        .dividend (a),
        .divisor  (b),
        .busy     (div_busy_s),
        .q        (div_q_s),
        .r        (div_r_s)
    );
`endif

    // Next-state, datapath and output-register logic for the operation FSM.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        err_d    = err_q;
`ifdef ARITH_DIV_EN
        div_start_s = 1'b0;
`endif
        accept_s = start & ready_q;
        sum_s    = {1'b0, a_q} + {1'b0, b_q};
        diff_s   = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);

        case (state_q)
            IDLE, FIN: begin
                if (accept_s) begin
                    op_d     = op;
                    a_d      = a;
                    b_d      = b;
                    acc_d    = {(2*W){1'b0}};
                    mcand_d  = {{W{1'b0}}, a};
                    mplier_d = b;
                    cnt_d    = {CW{1'b0}};
                    result_d = {(2*W){1'b0}};
                    rem_d    = {W{1'b0}};
                    neg_d    = 1'b0;
                    err_d    = 1'b0;
                    case (op)
                        OP_ADD:  state_d = EXEC1;
                        OP_SUB:  state_d = EXEC1;
                        OP_MUL:  state_d = MULT;
                        OP_DIV:  state_d = DIVD;
                        default: state_d = IDLE;
                    endcase
`ifdef ARITH_DIV_EN
                    div_start_s = (op == OP_DIV) && (b != {W{1'b0}});
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC1: begin
                if (op_q == OP_SUB) begin
                    result_d = {{W{1'b0}}, diff_s};
                    neg_d    = (b_q > a_q);
                end else begin
                    result_d = {{(W-1){1'b0}}, sum_s};
                    neg_d    = 1'b0;
                end
                state_d = FIN;
            end
            MULT: begin
                // Extra cycle after the last partial product moves acc into result.
                if (cnt_q == CW'(W)) begin
                    result_d = acc_q;
                    state_d  = FIN;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end else begin
                        acc_d = acc_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            DIVD: begin
`ifdef ARITH_DIV_EN
                if (b_q == {W{1'b0}}) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else if (!div_busy_s) begin
                    result_d = {{W{1'b0}}, div_q_s};
                    rem_d    = div_r_s;
                    state_d  = FIN;
                end else begin
                    state_d = DIVD;
                end
`else
                err_d   = 1'b1;
                state_d = FIN;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d  = (state_d == FIN);
        ready_d = (state_d == IDLE) || (state_d == FIN);
    end

    // Control and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            a_q      <= {W{1'b0}};
            b_q      <= {W{1'b0}};
            acc_q    <= {(2*W){1'b0}};
            mcand_q  <= {(2*W){1'b0}};
            mplier_q <= {W{1'b0}};
            cnt_q    <= {CW{1'b0}};
            result_q <= {(2*W){1'b0}};
            rem_q    <= {W{1'b0}};
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign result = result_q;
    assign rem    = rem_q;
    assign neg    = neg_q;
    assign err    = err_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed-vector bench for seq_arith_unit (W=7); DIV expectations follow ARITH_DIV_EN.
module tb_seq_arith_unit;
    import arith_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    op_t         op;
    logic [6:0]  a;
    logic [6:0]  b;
    logic        ready;
    logic        done;
    logic [13:0] result;
    logic [6:0]  rem;
    logic        neg;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    seq_arith_unit #(.W(7)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .result (result),
        .rem    (rem),
        .neg    (neg),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Issue one op; lat = negedges after the accept edge until done (0 = timeout).
    task automatic do_op(input op_t o, input logic [6:0] x, input logic [6:0] y, input bit poke,
                         output int lat, output logic rdy1, output logic [13:0] res1);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; rdy1 = 1'b1; res1 = 14'h3fff;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                rdy1 = ready;
                res1 = result;
            end
            if (done) begin
                lat = i;
                break;
            end
            if (poke && i >= 2 && i <= 5) begin
                start = 1'b1; op = OP_ADD; a = 7'd1; b = 7'd1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic expect_op(input string name, input op_t o, input logic [6:0] x, input logic [6:0] y,
                             input int e_lat, input int e_res, input int e_rem,
                             input logic e_neg, input logic e_err);
        int          lat;
        logic        rdy1;
        logic [13:0] res1;
        do_op(o, x, y, 1'b0, lat, rdy1, res1);
        check($sformatf("%s.lat", name), lat, e_lat);
        check($sformatf("%s.result", name), result, e_res);
        check($sformatf("%s.rem", name), rem, e_rem);
        check($sformatf("%s.neg", name), neg, e_neg);
        check($sformatf("%s.err", name), err, e_err);
        check($sformatf("%s.ready_drop", name), rdy1, 1'b0);
    endtask

    initial begin
        int          lat;
        logic        rdy1;
        logic [13:0] res1;
        int          saw_done;

        rst_n = 1'b0; start = 1'b0; op = OP_ADD; a = 7'd0; b = 7'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.ready", ready, 1'b1);
        check("rst.done", done, 1'b0);
        check("rst.result", result, 0);
        check("rst.rem", rem, 0);
        check("rst.neg", neg, 1'b0);
        check("rst.err", err, 1'b0);
        rst_n = 1'b1;

        expect_op("add100_27", OP_ADD, 7'd100, 7'd27, 2, 127, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("add.pulse", done, 1'b0);
        check("add.hold", result, 127);
        check("add.ready_back", ready, 1'b1);

        expect_op("add127_127", OP_ADD, 7'd127, 7'd127, 2, 254, 0, 1'b0, 1'b0);
        expect_op("sub5_9", OP_SUB, 7'd5, 7'd9, 2, 4, 0, 1'b1, 1'b0);
        expect_op("sub9_9", OP_SUB, 7'd9, 7'd9, 2, 0, 0, 1'b0, 1'b0);
        expect_op("sub100_27", OP_SUB, 7'd100, 7'd27, 2, 73, 0, 1'b0, 1'b0);

        do_op(OP_MUL, 7'd127, 7'd127, 1'b1, lat, rdy1, res1);
        check("mul127.lat", lat, 9);
        check("mul127.result", result, 16129);
        check("mul127.cleared", res1, 0);
        check("mul127.ready_drop", rdy1, 1'b0);
        check("mul127.neg", neg, 1'b0);
        @(negedge clk);
        check("mul127.pulse", done, 1'b0);
        check("mul127.idle", ready, 1'b1);
        check("mul127.hold", result, 16129);

        expect_op("mul13_11", OP_MUL, 7'd13, 7'd11, 9, 143, 0, 1'b0, 1'b0);
        expect_op("mul0_99", OP_MUL, 7'd0, 7'd99, 9, 0, 0, 1'b0, 1'b0);
        expect_op("mul1_127", OP_MUL, 7'd1, 7'd127, 9, 127, 0, 1'b0, 1'b0);

`ifdef ARITH_DIV_EN
        expect_op("div100_7", OP_DIV, 7'd100, 7'd7, 9, 14, 2, 1'b0, 1'b0);
        expect_op("div127_1", OP_DIV, 7'd127, 7'd1, 9, 127, 0, 1'b0, 1'b0);
        expect_op("div6_13", OP_DIV, 7'd6, 7'd13, 9, 0, 6, 1'b0, 1'b0);
        expect_op("div5_0", OP_DIV, 7'd5, 7'd0, 2, 0, 0, 1'b0, 1'b1);
`else
        expect_op("div100_7", OP_DIV, 7'd100, 7'd7, 2, 0, 0, 1'b0, 1'b1);
        expect_op("div5_0", OP_DIV, 7'd5, 7'd0, 2, 0, 0, 1'b0, 1'b1);
`endif
        expect_op("add1_2", OP_ADD, 7'd1, 7'd2, 2, 3, 0, 1'b0, 1'b0);

        // Abort a multiply with reset part-way through.
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 7'd127; b = 7'd127;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort.ready", ready, 1'b1);
        check("abort.result", result, 0);
        check("abort.err", err, 1'b0);
        check("abort.done", done, 1'b0);
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        check("abort.no_done", saw_done, 0);
        expect_op("add1_1", OP_ADD, 7'd1, 7'd1, 2, 2, 0, 1'b0, 1'b0);

        // Back-to-back: start held high so the second op is taken in the FIN cycle.
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 7'd3; b = 7'd4;
        @(posedge clk);
        #1 a = 7'd20; b = 7'd30;
        @(negedge clk);
        check("b2b.first_wait", done, 1'b0);
        @(negedge clk);
        check("b2b.first_done", done, 1'b1);
        check("b2b.first_result", result, 7);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b.accepted", ready, 1'b0);
        check("b2b.cleared", result, 0);
        @(negedge clk);
        check("b2b.second_done", done, 1'b1);
        check("b2b.second_result", result, 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
